// File: rtl/serial_add_pkg.sv
// serial_add_pkg
// Shared type definitions for the bit-serial adder controller.
//   sa_state_t : controller FSM state (IDLE -> RUN -> DONE -> IDLE)
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } sa_state_t;

endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// fa_cell
// Single-bit full adder. This is the only arithmetic in the serial adder;
// the controller feeds it one operand bit pair per clock.
// Ports:
//   a, b  : operand bits
//   cin   : carry in
//   sum   : a ^ b ^ cin
//   cout  : carry out
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
// Bit-serial adder controller: latches WIDTH-bit operands on accept, then
// pushes them LSB first through one fa_cell, one bit per clock, carrying
// through a registered carry. The result appears WIDTH clocks after accept
// and is held until the consumer takes it.
//
// Optional build macro: SERIAL_ADD_OVF_EN adds the 'ovf' output (signed
// two's-complement overflow of the held result).
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   operands presented        in_ready  controller accepts operands
//   a, b       WIDTH-bit addends         cin       carry into bit 0
//   out_valid  result available          out_ready consumer takes result
//   sum        WIDTH-bit result          cout      carry out of bit WIDTH-1
//   busy       high while bits are being processed
//   ovf        (SERIAL_ADD_OVF_EN only) signed overflow of the result
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);
  // Index of the final bit; the counter stops here rather than wrapping.
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sa_state_t        state_reg,  state_next;
  logic [WIDTH-1:0] a_sr_reg,   a_sr_next;
  logic [WIDTH-1:0] b_sr_reg,   b_sr_next;
  logic [WIDTH-1:0] sum_sr_reg, sum_sr_next;
  logic             carry_reg,  carry_next;
  logic [CW-1:0]    cnt_reg,    cnt_next;
  logic [WIDTH-1:0] sum_reg,    sum_next;
  logic             cout_reg,   cout_next;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_reg,    ovf_next;
`endif

  logic fa_sum;
  logic fa_cout;

  fa_cell u_fa (
    .a    (a_sr_reg[0]),
    .b    (b_sr_reg[0]),
    .cin  (carry_reg),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      a_sr_reg   <= '0;
      b_sr_reg   <= '0;
      sum_sr_reg <= '0;
      carry_reg  <= 1'b0;
      cnt_reg    <= '0;
      sum_reg    <= '0;
      cout_reg   <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_reg    <= 1'b0;
`endif
    end else begin
      state_reg  <= state_next;
      a_sr_reg   <= a_sr_next;
      b_sr_reg   <= b_sr_next;
      sum_sr_reg <= sum_sr_next;
      carry_reg  <= carry_next;
      cnt_reg    <= cnt_next;
      sum_reg    <= sum_next;
      cout_reg   <= cout_next;
`ifdef SERIAL_ADD_OVF_EN
      ovf_reg    <= ovf_next;
`endif
    end
  end

  always_comb begin
    state_next  = state_reg;
    a_sr_next   = a_sr_reg;
    b_sr_next   = b_sr_reg;
    sum_sr_next = sum_sr_reg;
    carry_next  = carry_reg;
    cnt_next    = cnt_reg;
    sum_next    = sum_reg;
    cout_next   = cout_reg;
`ifdef SERIAL_ADD_OVF_EN
    ovf_next    = ovf_reg;
`endif
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;

    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        // Operands are only sampled here, so anything on a/b outside an
        // accept never reaches the datapath.
        if (in_valid) begin
          a_sr_next  = a;
          b_sr_next  = b;
          carry_next = cin;
          cnt_next   = '0;
          state_next = RUN;
        end
      end

      RUN: begin
        busy        = 1'b1;
        sum_sr_next = {fa_sum, sum_sr_reg[WIDTH-1:1]};
        a_sr_next   = a_sr_reg >> 1;
        b_sr_next   = b_sr_reg >> 1;
        carry_next  = fa_cout;
        if (cnt_reg == LAST) begin
          state_next = DONE;
          sum_next   = {fa_sum, sum_sr_reg[WIDTH-1:1]};
          cout_next  = fa_cout;
`ifdef SERIAL_ADD_OVF_EN
          // carry_reg is the carry into the MSB on this final step.
          ovf_next   = carry_reg ^ fa_cout;
`endif
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign sum  = sum_reg;
  assign cout = cout_reg;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf  = ovf_reg;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl
// Scoreboard bench for serial_add_ctrl (WIDTH=8). The driver pushes the
// arithmetic expectation for every accepted operation; a negedge monitor
// compares the held result on every out_valid cycle and pops on transfer.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference: plain integer addition; overflow when both addends share a
  // sign and the result's sign differs.
  function automatic exp_t model(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc);
    exp_t e;
    logic [W:0] full;
    full   = {1'b0, xa} + {1'b0, xb} + {{W{1'b0}}, xc};
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (xa[W-1] == xb[W-1]) && (full[W-1] != xa[W-1]);
    return e;
  endfunction

  // Monitor: result must match the head of the scoreboard on every cycle
  // it is presented (covers stability under backpressure).
  always @(negedge clk) begin
    if (reset_n && out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        check("result_sum", 32'(sum), 32'(sb[0].sum));
        check("result_cout", 32'(cout), 32'(sb[0].cout));
`ifdef SERIAL_ADD_OVF_EN
        check("result_ovf", 32'(ovf), 32'(sb[0].ovf));
`endif
        if (out_ready) begin
          $display("txn: sum=0x%02h cout=%0d", sum, cout);
          void'(sb.pop_front());
        end
      end
    end
  end

  // Called at posedge+1 with the controller idle.
  task automatic send(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc, input int bp);
    int lat;
    check("in_ready_idle", 32'(in_ready), 32'd1);
    a = xa; b = xb; cin = xc; in_valid = 1'b1;
    out_ready = (bp == 0);
    @(posedge clk);
    sb.push_back(model(xa, xb, xc));
    #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 4 * W) begin
      check("busy_run", 32'(busy), 32'd1);
      check("in_ready_run", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(W));
    if (bp > 0) begin
      repeat (bp) begin
        // Offered operands must be ignored while a result is held.
        in_valid = 1'b1; a = W'($urandom); b = W'($urandom);
        check("in_ready_done", 32'(in_ready), 32'd0);
        check("out_valid_held", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check("idle_in_ready", 32'(in_ready), 32'd1);
    check("idle_out_valid", 32'(out_valid), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    send(8'h5A, 8'h3C, 1'b0, 0);
    send(8'hFF, 8'h01, 1'b0, 0);
    send(8'hFF, 8'hFF, 1'b1, 0);
    send(8'h12, 8'h34, 1'b0, 5);
`ifdef SERIAL_ADD_OVF_EN
    send(8'h7F, 8'h01, 1'b0, 1);
    send(8'h80, 8'h80, 1'b0, 0);
`endif

    // Reset in the middle of RUN (counter at 3).
    check("in_ready_idle", 32'(in_ready), 32'd1);
    a = 8'hAA; b = 8'h55; cin = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midop_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_sum", 32'(sum), 32'd0);
    check("midrst_cout", 32'(cout), 32'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (W + 3) begin
      @(posedge clk); #1;
      check("no_stale_valid", 32'(out_valid), 32'd0);
    end
    send(8'h01, 8'h02, 1'b0, 0);

    for (int i = 0; i < 30; i++) begin
      send(W'($urandom), W'($urandom), 1'($urandom), $urandom_range(0, 3));
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
